// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB hue cycler.
// Sector encoding, duty width and sector sequencing.
package rgb_pkg;

   typedef enum logic [2:0] {
      SEC_RY = 3'd0,
      SEC_YG = 3'd1,
      SEC_GC = 3'd2,
      SEC_CB = 3'd3,
      SEC_BM = 3'd4,
      SEC_MR = 3'd5
   } sector_t;

   function automatic int duty_width(input int interval);
      return (interval > 1) ? $clog2(interval) : 1;
   endfunction

   function automatic sector_t sec_next(input sector_t s);
      return (s == SEC_MR) ? SEC_RY : sector_t'(s + 3'd1);
   endfunction

   function automatic sector_t sec_prev(input sector_t s);
      return (s == SEC_RY) ? SEC_MR : sector_t'(s - 3'd1);
   endfunction

endpackage

// File: rtl/rgb_hue_cycler_tick_gen.sv
// Step prescaler: counts enabled cycles, strobes on the last one.
// The strobe is combinational so the consumer updates on the same edge.
module tick_gen #(
   parameter int STEP_CYCLES = 33333
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic step
);

   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      step  = 1'b0;
      if (enable) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            step  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rgb_hue_cycler.sv
// Hue wheel walker driving three PWM duty values, six linear sectors.
// Define RGB_HUE_REVERSE_EN to add the reverse direction input.
module rgb_hue_cycler
   import rgb_pkg::*;
#(
   parameter int PWM_INTERVAL     = 1200,
   parameter int STEPS_PER_SECTOR = 60,
   parameter int STEP_CYCLES      = 33333,
   localparam int W = duty_width(PWM_INTERVAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
`ifdef RGB_HUE_REVERSE_EN
   input  logic         reverse,
`endif
   output logic [W-1:0] pwm_value_r,
   output logic [W-1:0] pwm_value_g,
   output logic [W-1:0] pwm_value_b,
   output logic [2:0]   sector,
   output logic         wrap
);

   localparam int INC = PWM_INTERVAL / STEPS_PER_SECTOR;
   localparam int SW  = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;
   localparam logic [W-1:0]  FULL  = W'(PWM_INTERVAL);
   localparam logic [W-1:0]  INC_W = W'(INC);
   localparam logic [SW-1:0] LAST  = SW'(STEPS_PER_SECTOR - 1);

   if (PWM_INTERVAL % STEPS_PER_SECTOR != 0) begin : g_chk_div
      $error("PWM_INTERVAL must be a multiple of STEPS_PER_SECTOR");
   end
   if (PWM_INTERVAL >= 2**W) begin : g_chk_full
      $error("PWM_INTERVAL not representable in duty width");
   end
   if (STEP_CYCLES < 1) begin : g_chk_step
      $error("STEP_CYCLES must be at least 1");
   end

   logic tick;
   logic rev;

`ifdef RGB_HUE_REVERSE_EN
   assign rev = reverse;
`else
   assign rev = 1'b0;
`endif

   tick_gen #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .step   (tick)
   );

   sector_t       sec_q, sec_d;
   logic [SW-1:0] step_q, step_d;
   logic [W-1:0]  up_q, up_d;
   logic [W-1:0]  down;
   logic [W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic          wrap_q, wrap_d;

   // up is k*INC, kept as a running sum so no multiplier is needed
   always_comb begin
      sec_d  = sec_q;
      step_d = step_q;
      up_d   = up_q;
      wrap_d = 1'b0;
      if (tick) begin
         if (rev) begin
            if (step_q == '0) begin
               step_d = LAST;
               up_d   = FULL - INC_W;
               sec_d  = sec_prev(sec_q);
               wrap_d = (sec_q == SEC_RY);
            end else begin
               step_d = step_q - SW'(1);
               up_d   = up_q - INC_W;
            end
         end else begin
            if (step_q == LAST) begin
               step_d = '0;
               up_d   = '0;
               sec_d  = sec_next(sec_q);
               wrap_d = (sec_q == SEC_MR);
            end else begin
               step_d = step_q + SW'(1);
               up_d   = up_q + INC_W;
            end
         end
      end
   end

   always_comb begin
      down = FULL - up_d;
      r_d  = FULL;
      g_d  = '0;
      b_d  = '0;
      unique case (sec_d)
         SEC_RY: begin r_d = FULL; g_d = up_d; b_d = '0;   end
         SEC_YG: begin r_d = down; g_d = FULL; b_d = '0;   end
         SEC_GC: begin r_d = '0;   g_d = FULL; b_d = up_d; end
         SEC_CB: begin r_d = '0;   g_d = down; b_d = FULL; end
         SEC_BM: begin r_d = up_d; g_d = '0;   b_d = FULL; end
         SEC_MR: begin r_d = FULL; g_d = '0;   b_d = down; end
         default: begin r_d = FULL; g_d = '0;  b_d = '0;   end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_q  <= SEC_RY;
         step_q <= '0;
         up_q   <= '0;
         r_q    <= FULL;
         g_q    <= '0;
         b_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         sec_q  <= sec_d;
         step_q <= step_d;
         up_q   <= up_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         wrap_q <= wrap_d;
      end
   end

   assign pwm_value_r = r_q;
   assign pwm_value_g = g_q;
   assign pwm_value_b = b_q;
   assign sector      = sec_q;
   assign wrap        = wrap_q;

endmodule
